// File: rtl/glip_fifo_bridge.sv
// rtl/glip_fifo_bridge.sv - host/logic word bridge with two FIFO channels and reset generation
// Optional GLIP_FILL_LEVEL_EN exposes per-channel occupancy outputs.

module glip_fifo_chan #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready
`ifdef GLIP_FILL_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr_q[AW-1:0]];
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

`ifdef GLIP_FILL_LEVEL_EN
    assign level = wr_ptr_q - rd_ptr_q;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
endmodule

module glip_fifo_bridge #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         host_in_data,
    input  logic                     host_in_valid,
    output logic                     host_in_ready,
    output logic [WIDTH-1:0]         fifo_in_data,
    output logic                     fifo_in_valid,
    input  logic                     fifo_in_ready,
    input  logic [WIDTH-1:0]         fifo_out_data,
    input  logic                     fifo_out_valid,
    output logic                     fifo_out_ready,
    output logic [WIDTH-1:0]         host_out_data,
    output logic                     host_out_valid,
    input  logic                     host_out_ready,
    input  logic                     ctrl_wr,
    input  logic                     ctrl_data,
    output logic                     com_rst,
    output logic                     logic_rst
`ifdef GLIP_FILL_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   fifo_in_level,
    output logic [$clog2(DEPTH):0]   host_out_level
`endif
);
    logic [1:0] sync_q, sync_d;
    logic       ctrl_q, ctrl_d;

    // Asynchronous assert, two-edge synchronous release.
    always_comb begin
        sync_d = {sync_q[0], 1'b0};
        ctrl_d = ctrl_q;
        if (com_rst)      ctrl_d = 1'b0;
        else if (ctrl_wr) ctrl_d = ctrl_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            ctrl_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign com_rst   = sync_q[1];
    assign logic_rst = com_rst | ctrl_q;

    glip_fifo_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (com_rst),
        .wr_data  (host_in_data),
        .wr_valid (host_in_valid),
        .wr_ready (host_in_ready),
        .rd_data  (fifo_in_data),
        .rd_valid (fifo_in_valid),
        .rd_ready (fifo_in_ready)
`ifdef GLIP_FILL_LEVEL_EN
        ,
        .level    (fifo_in_level)
`endif
    );

    glip_fifo_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (com_rst),
        .wr_data  (fifo_out_data),
        .wr_valid (fifo_out_valid),
        .wr_ready (fifo_out_ready),
        .rd_data  (host_out_data),
        .rd_valid (host_out_valid),
        .rd_ready (host_out_ready)
`ifdef GLIP_FILL_LEVEL_EN
        ,
        .level    (host_out_level)
`endif
    );
endmodule

// File: tb/tb_glip_fifo_bridge.sv
// tb/tb_glip_fifo_bridge.sv - scoreboard bench for glip_fifo_bridge against a queue model

module tb_glip_fifo_bridge;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] host_in_data;
    logic             host_in_valid;
    logic             host_in_ready;
    logic [WIDTH-1:0] fifo_in_data;
    logic             fifo_in_valid;
    logic             fifo_in_ready;
    logic [WIDTH-1:0] fifo_out_data;
    logic             fifo_out_valid;
    logic             fifo_out_ready;
    logic [WIDTH-1:0] host_out_data;
    logic             host_out_valid;
    logic             host_out_ready;
    logic             ctrl_wr;
    logic             ctrl_data;
    logic             com_rst;
    logic             logic_rst;
`ifdef GLIP_FILL_LEVEL_EN
    logic [$clog2(DEPTH):0] fifo_in_level;
    logic [$clog2(DEPTH):0] host_out_level;
`endif

    glip_fifo_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .fifo_in_data   (fifo_in_data),
        .fifo_in_valid  (fifo_in_valid),
        .fifo_in_ready  (fifo_in_ready),
        .fifo_out_data  (fifo_out_data),
        .fifo_out_valid (fifo_out_valid),
        .fifo_out_ready (fifo_out_ready),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .ctrl_wr        (ctrl_wr),
        .ctrl_data      (ctrl_data),
        .com_rst        (com_rst),
        .logic_rst      (logic_rst)
`ifdef GLIP_FILL_LEVEL_EN
        ,
        .fifo_in_level  (fifo_in_level),
        .host_out_level (host_out_level)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q_in[$];
    logic [WIDTH-1:0] q_out[$];
    int               rel_cnt;
    logic             ctrl_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Edges seen since rst fell; communication reset is expected until two have passed.
    always @(posedge clk or posedge rst) begin
        if (rst) rel_cnt <= 0;
        else if (rel_cnt < 3) rel_cnt <= rel_cnt + 1;
    end

    // Monitor: compares DUT against the model, then applies the transfers of the coming edge.
    always @(negedge clk) begin
        logic flush;
        logic pop_in, push_in, pop_out, push_out;
        flush = rst || (rel_cnt < 2);
        if (flush) begin
            q_in.delete();
            q_out.delete();
            ctrl_m = 1'b0;
        end
        chk("com_rst", com_rst, flush);
        chk("logic_rst", logic_rst, flush | ctrl_m);
        chk("host_in_ready", host_in_ready, q_in.size() < DEPTH);
        chk("fifo_in_valid", fifo_in_valid, q_in.size() > 0);
        if (q_in.size() > 0) chk("fifo_in_data", fifo_in_data, q_in[0]);
        chk("fifo_out_ready", fifo_out_ready, q_out.size() < DEPTH);
        chk("host_out_valid", host_out_valid, q_out.size() > 0);
        if (q_out.size() > 0) chk("host_out_data", host_out_data, q_out[0]);
`ifdef GLIP_FILL_LEVEL_EN
        chk("fifo_in_level", fifo_in_level, q_in.size());
        chk("host_out_level", host_out_level, q_out.size());
`endif
        if (!flush) begin
            pop_in   = fifo_in_ready && (q_in.size() > 0);
            push_in  = host_in_valid && (q_in.size() < DEPTH);
            pop_out  = host_out_ready && (q_out.size() > 0);
            push_out = fifo_out_valid && (q_out.size() < DEPTH);
            if (pop_in)   void'(q_in.pop_front());
            if (push_in)  q_in.push_back(host_in_data);
            if (pop_out)  void'(q_out.pop_front());
            if (push_out) q_out.push_back(fifo_out_data);
            if (ctrl_wr)  ctrl_m = ctrl_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_in_valid  = 1'b0;
        fifo_in_ready  = 1'b0;
        fifo_out_valid = 1'b0;
        host_out_ready = 1'b0;
        ctrl_wr        = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        host_in_data   = '0;
        fifo_out_data  = '0;
        ctrl_data      = 1'b0;
        idle_inputs();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("com_rst_edge1", com_rst, 1'b1);
        tick();
        chk("com_rst_edge2", com_rst, 1'b0);
        chk("logic_rst_rel", logic_rst, 1'b0);
        chk("rel_in_ready", host_in_ready, 1'b1);
        chk("rel_out_ready", fifo_out_ready, 1'b1);

        // Three words held, then drained in order.
        host_in_valid = 1'b1;
        host_in_data  = 16'hA5A5;
        tick();
        chk("first_word_latency", fifo_in_valid, 1'b1);
        host_in_data = 16'h0001;
        tick();
        host_in_data = 16'hFFFF;
        tick();
        host_in_valid = 1'b0;
        fifo_in_ready = 1'b1;
        repeat (4) tick();
        chk("drained_valid", fifo_in_valid, 1'b0);
        fifo_in_ready = 1'b0;

        // Fill the out channel, then push and pop together while full.
        fifo_out_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            fifo_out_data = 16'($urandom);
            tick();
        end
        chk("out_full_ready", fifo_out_ready, 1'b0);
        fifo_out_data  = 16'h1234;
        host_out_ready = 1'b1;
        tick();
        chk("full_pushpop_ready", fifo_out_ready, 1'b1);
`ifdef GLIP_FILL_LEVEL_EN
        chk("full_pushpop_level", host_out_level, DEPTH - 1);
`endif
        fifo_out_valid = 1'b0;
        repeat (DEPTH + 1) tick();
        host_out_ready = 1'b0;

        // Continuous streaming across pointer wrap.
        host_in_valid = 1'b1;
        fifo_in_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            host_in_data = 16'(i * 977 + 3);
            tick();
        end
        host_in_valid = 1'b0;
        repeat (2) tick();
        fifo_in_ready = 1'b0;

        // Logic reset request with words queued.
        host_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_in_data = 16'($urandom);
            tick();
        end
        host_in_valid = 1'b0;
        ctrl_wr   = 1'b1;
        ctrl_data = 1'b1;
        tick();
        ctrl_wr = 1'b0;
        chk("ctrl_logic_rst_set", logic_rst, 1'b1);
        chk("ctrl_com_rst_low", com_rst, 1'b0);
        chk("ctrl_fifo_intact", fifo_in_valid, 1'b1);
        ctrl_wr   = 1'b1;
        ctrl_data = 1'b0;
        tick();
        ctrl_wr = 1'b0;
        chk("ctrl_logic_rst_clr", logic_rst, 1'b0);

        // Reset with words queued.
        host_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_in_data = 16'($urandom);
            tick();
        end
        host_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", fifo_in_valid, 1'b0);
        chk("async_rst_com", com_rst, 1'b1);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_empty", fifo_in_valid, 1'b0);

        // Randomized traffic on both channels.
        for (int n = 0; n < 3000; n++) begin
            host_in_valid  = 1'($urandom_range(0, 1));
            host_in_data   = 16'($urandom);
            fifo_in_ready  = ($urandom_range(0, 3) != 0);
            fifo_out_valid = 1'($urandom_range(0, 1));
            fifo_out_data  = 16'($urandom);
            host_out_ready = ($urandom_range(0, 2) == 0);
            ctrl_wr        = ($urandom_range(0, 40) == 0);
            ctrl_data      = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
